// File: rtl/dmem_pkg.sv
// Shared constants and FSM state encoding for the data-memory copy engine.
package dmem_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/dmem_copy_engine.sv
// Byte-wise memory-to-memory copy engine sitting between the core and a
// single-port data memory. While idle the core owns the port; while a copy
// runs the engine alternates READ/WRITE cycles and the core write is dropped.
module dmem_copy_engine
    import dmem_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW-1:0] len,
    input  logic          cpu_mem_write,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          busy,
    output logic          done,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [AW-1:0] ONE = AW'(1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_src_ptr;
    logic [AW-1:0] r_dst_ptr;
    logic [AW-1:0] r_count;
    logic [DW-1:0] r_data;
    logic          w_accept;

    // A copy is only taken from IDLE; zero length goes straight to DONE.
    assign w_accept  = (r_state == ST_IDLE) && start && (len != '0);
    assign cpu_rdata = mem_rdata;

    // State register; reset wins over any start in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Copy datapath: latch request, capture read data, step pointers on write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_src_ptr <= '0;
            r_dst_ptr <= '0;
            r_count   <= '0;
            r_data    <= '0;
        end else begin
            if (w_accept) begin
                r_src_ptr <= src_addr;
                r_dst_ptr <= dst_addr;
                r_count   <= len;
            end
            if (r_state == ST_READ) r_data <= mem_rdata;
            if (r_state == ST_WRITE) begin
                // Natural AW-bit wrap gives modulo-2^AW pointer stepping.
                r_src_ptr <= r_src_ptr + ONE;
                r_dst_ptr <= r_dst_ptr + ONE;
                r_count   <= r_count - ONE;
            end
        end
    end

    // Next state and memory-port mux; core passes through outside a copy.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        mem_write   = cpu_mem_write;
        mem_addr    = cpu_addr;
        mem_wdata   = cpu_wdata;
        unique case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = (len == '0) ? ST_DONE : ST_READ;
            end
            ST_READ: begin
                busy        = 1'b1;
                mem_write   = 1'b0;
                mem_addr    = r_src_ptr;
                mem_wdata   = r_data;
                w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                busy        = 1'b1;
                mem_write   = 1'b1;
                mem_addr    = r_dst_ptr;
                mem_wdata   = r_data;
                w_state_nxt = (r_count == ONE) ? ST_DONE : ST_READ;
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Scoreboard bench for dmem_copy_engine: a behavioural memory sits on the
// memory port, a reference copy model queues the expected read addresses and
// write beats, and a negedge monitor pops and compares them.
module tb_dmem_copy_engine;

    localparam int AW = 8;
    localparam int DW = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wbeat_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] src_addr, dst_addr, len;
    logic          cpu_mem_write;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          busy, done;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] mem     [256];
    logic [DW-1:0] exp_mem [256];

    logic [AW-1:0] rq[$];
    wbeat_t        wq[$];

    int n_chk  = 0;
    int n_pass = 0;
    int busy_cnt, done_cnt, wr_cnt;

    always #5 clk = ~clk;

    dmem_copy_engine #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .cpu_mem_write(cpu_mem_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .busy(busy), .done(done),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Behavioural data memory: combinational read, posedge write.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else             n_pass++;
    endtask

    // Monitor: count activity and compare every engine-driven beat.
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (mem_write) wr_cnt++;
        if (busy && !mem_write) begin
            if (rq.size() == 0) chk("rd_unexpected", {24'd0, mem_addr}, 32'hFFFF);
            else                chk("rd_addr", {24'd0, mem_addr}, {24'd0, rq.pop_front()});
        end
        if (busy && mem_write) begin
            if (wq.size() == 0) chk("wr_unexpected", {24'd0, mem_addr}, 32'hFFFF);
            else begin
                wbeat_t b;
                b = wq.pop_front();
                chk("wr_addr", {24'd0, mem_addr}, {24'd0, b.addr});
                chk("wr_data", {24'd0, mem_wdata}, {24'd0, b.data});
            end
        end
        chk("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, mem_rdata});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_mem_write = 1'b1; cpu_addr = a; cpu_wdata = d;
        tick();
        cpu_mem_write = 1'b0;
    endtask

    // Reference model: forward byte copy over a snapshot of memory.
    task automatic model(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
        for (int i = 0; i < 256; i++) exp_mem[i] = mem[i];
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] sa, da;
            wbeat_t b;
            sa = s + AW'(i);
            da = d + AW'(i);
            exp_mem[da] = exp_mem[sa];
            rq.push_back(sa);
            b.addr = da; b.data = exp_mem[sa];
            wq.push_back(b);
        end
    endtask

    task automatic pulse_start(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
        busy_cnt = 0; done_cnt = 0; wr_cnt = 0;
        src_addr = s; dst_addr = d; len = AW'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Full copy with latency/busy/done checks; optional core write held while busy.
    task automatic run_copy(input string tag, input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input int n, input bit cpu_hold);
        int k;
        bit seen;
        model(s, d, n);
        pulse_start(s, d, n);
        k = 1; seen = 0;
        while (k < 1000) begin
            if (cpu_hold) begin
                cpu_mem_write = busy; cpu_addr = 8'h06; cpu_wdata = 8'h5A;
            end
            if (done) begin seen = 1; break; end
            tick();
            k++;
        end
        cpu_mem_write = 1'b0;
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_done_lat"}, 32'(k), 32'(2 * n + 1));
        tick();
        tick();
        chk({tag, "_busy_cyc"}, 32'(busy_cnt), 32'(2 * n));
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({tag, "_wr_cnt"}, 32'(wr_cnt), 32'(n));
        chk({tag, "_sb_empty"}, 32'(rq.size() + wq.size()), 32'd0);
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] da;
            da = d + AW'(i);
            chk({tag, "_mem"}, {24'd0, mem[da]}, {24'd0, exp_mem[da]});
        end
        rq.delete(); wq.delete();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        src_addr = '0; dst_addr = '0; len = '0;
        cpu_mem_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        busy_cnt = 0; done_cnt = 0; wr_cnt = 0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        cpu_mem_write = 1'b1; cpu_addr = 8'h80; cpu_wdata = 8'h77;
        #1;
        chk("rst_wr_pass", 32'(mem_write), 32'd1);
        chk("rst_addr_pass", {24'd0, mem_addr}, 32'h80);
        cpu_mem_write = 1'b0;
        #1;
        chk("rst_wr_pass0", 32'(mem_write), 32'd0);
        reset = 1'b0;
        tick();

        // Basic copy of four bytes.
        cpu_wr(8'h00, 8'h11); cpu_wr(8'h01, 8'h22);
        cpu_wr(8'h02, 8'h33); cpu_wr(8'h03, 8'h44);
        run_copy("c4", 8'h00, 8'h04, 4, 1'b0);
        chk("c4_m7", {24'd0, mem[7]}, 32'h44);

        // Zero length: done next cycle, never busy, no write.
        begin
            int k;
            pulse_start(8'h00, 8'h20, 0);
            chk("len0_done", 32'(done), 32'd1);
            chk("len0_busy", 32'(busy), 32'd0);
            k = 0;
            tick(); tick();
            chk("len0_busy_cyc", 32'(busy_cnt), 32'd0);
            chk("len0_wr_cnt", 32'(wr_cnt), 32'd0);
            chk("len0_done_cnt", 32'(done_cnt), 32'd1);
        end

        // Forward overlap replicates the first byte.
        cpu_wr(8'h00, 8'hAA);
        run_copy("ovl", 8'h00, 8'h01, 3, 1'b0);
        chk("ovl_m3", {24'd0, mem[3]}, 32'hAA);

        // Source pointer wrap.
        cpu_wr(8'hFE, 8'hC1); cpu_wr(8'hFF, 8'hC2); cpu_wr(8'h00, 8'hC3);
        run_copy("wrap", 8'hFE, 8'h10, 3, 1'b0);
        chk("wrap_m12", {24'd0, mem[8'h12]}, 32'hC3);

        // Core write is dropped while busy, honoured when idle.
        cpu_wr(8'h06, 8'h3C);
        run_copy("cpu", 8'h30, 8'h40, 4, 1'b1);
        chk("cpu_drop", {24'd0, mem[6]}, 32'h3C);
        cpu_wr(8'h06, 8'h5A);
        chk("cpu_idle_wr", {24'd0, mem[6]}, 32'h5A);

        // Start is ignored outside IDLE.
        begin
            model(8'h00, 8'h60, 2);
            pulse_start(8'h00, 8'h60, 2);
            src_addr = 8'h90; dst_addr = 8'hA0; len = 8'd7;
            start = 1'b1;
            tick();
            start = 1'b0;
            repeat (6) tick();
            chk("ign_busy_cyc", 32'(busy_cnt), 32'd4);
            chk("ign_wr_cnt", 32'(wr_cnt), 32'd2);
            chk("ign_sb_empty", 32'(rq.size() + wq.size()), 32'd0);
            rq.delete(); wq.delete();
        end

        // Reset in the second WRITE of a four-byte copy.
        cpu_wr(8'h52, 8'hEE); cpu_wr(8'h53, 8'hEE);
        model(8'h00, 8'h50, 2);
        pulse_start(8'h00, 8'h50, 4);
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        reset = 1'b0;
        tick(); tick();
        chk("abort_done_cnt", 32'(done_cnt), 32'd0);
        chk("abort_m50", {24'd0, mem[8'h50]}, {24'd0, exp_mem[8'h50]});
        chk("abort_m51", {24'd0, mem[8'h51]}, {24'd0, exp_mem[8'h51]});
        chk("abort_m52", {24'd0, mem[8'h52]}, 32'hEE);
        chk("abort_sb_empty", 32'(rq.size() + wq.size()), 32'd0);
        rq.delete(); wq.delete();

        // Reset beats start in the same cycle.
        src_addr = 8'h00; dst_addr = 8'h70; len = 8'd2;
        start = 1'b1; reset = 1'b1;
        tick();
        start = 1'b0; reset = 1'b0;
        chk("rst_prio_busy", 32'(busy), 32'd0);
        chk("rst_prio_done", 32'(done), 32'd0);

        // Engine still accepts work after the abort.
        run_copy("post", 8'h00, 8'h58, 2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_copy_engine.md
DMEM_COPY_ENGINE -- requirements
Module: dmem_copy_engine

Interface
REQ-001 SHALL have parameter AW, default 8, data memory address width.
REQ-002 SHALL have parameter DW, default 8, data memory word width.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  copy request; sampled only in IDLE.
REQ-006 SHALL have port src_addr  in  AW  first source address.
REQ-007 SHALL have port dst_addr  in  AW  first destination address.
REQ-008 SHALL have port len  in  AW  byte count; 0 = no-op.
REQ-009 SHALL have port cpu_mem_write  in  1  core write enable.
REQ-010 SHALL have port cpu_addr  in  AW  core address.
REQ-011 SHALL have port cpu_wdata  in  DW  core write data.
REQ-012 SHALL have port cpu_rdata  out  DW  core read data.
REQ-013 SHALL have port busy  out  1  high while a copy owns the memory port.
REQ-014 SHALL have port done  out  1  one-cycle completion pulse.
REQ-015 SHALL have port mem_write  out  1  to data memory write enable.
REQ-016 SHALL have port mem_addr  out  AW  to data memory address.
REQ-017 SHALL have port mem_wdata  out  DW  to data memory write data.
REQ-018 SHALL have port mem_rdata  in  DW  from data memory, combinational read of mem_addr.

Function
REQ-019 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-020 IDLE, start=1, len!=0: SHALL latch src_addr/dst_addr/len into src_ptr/dst_ptr/count; go READ.
REQ-021 IDLE, start=1, len=0: SHALL go DONE; no memory write.
REQ-022 READ: mem_addr=src_ptr, mem_write=0; SHALL capture mem_rdata into data_reg at edge; go WRITE.
REQ-023 WRITE: mem_addr=dst_ptr, mem_wdata=data_reg, mem_write=1; SHALL increment both pointers modulo 2^AW and decrement count.
REQ-024 WRITE exit: count==1 -> DONE, else -> READ.
REQ-025 DONE: done=1, busy=0; SHALL return to IDLE next cycle.
REQ-026 busy SHALL be 1 exactly in READ and WRITE; a copy of N bytes SHALL hold busy for 2N cycles.
REQ-027 start outside IDLE SHALL be ignored (no queuing).
REQ-028 IDLE/DONE: mem_write/mem_addr/mem_wdata SHALL pass through cpu_mem_write/cpu_addr/cpu_wdata combinationally.
REQ-029 READ/WRITE: cpu_mem_write SHALL be dropped (never reaches memory); core must not write while busy.
REQ-030 cpu_rdata SHALL equal mem_rdata in all states.
REQ-031 Overlapping ranges: SHALL copy forward byte by byte in order; result is defined by that order (dst=src+1 replicates first byte).
REQ-032 Pointer wrap: 0xFF+1 SHALL become 0x00, no error.

Reset
REQ-033 reset=1 at edge SHALL force IDLE; src_ptr, dst_ptr, count, data_reg = 0.
REQ-034 After reset: busy=0, done=0, mem_write follows cpu_mem_write.
REQ-035 Reset mid-copy SHALL abort; already-written bytes remain; no done pulse.
REQ-036 reset SHALL take priority over start in the same cycle.

Structure
REQ-037 Package dmem_pkg SHALL hold the state enum and AW/DW default constants.
REQ-038 Single module, no sub-module; datapath mux and FSM in one file.

Verification
REQ-039 Preload mem[0..3]=11,22,33,44; start src=0 dst=4 len=4 -> busy 8 cycles, done pulse once, mem[4..7]=11,22,33,44.
REQ-040 start len=0 -> done next cycle, busy never 1, no mem_write.
REQ-041 mem[0]=AA; src=0 dst=1 len=3 -> mem[1..3]=AA (forward overlap).
REQ-042 src=FE dst=10 len=3 -> reads FE,FF,00 in order, writes 10,11,12.
REQ-043 During copy, cpu_mem_write=1 cpu_addr=6 cpu_wdata=5A -> mem[6] unchanged; same write in IDLE -> mem[6]=5A.
REQ-044 reset in second WRITE of len=4 copy -> IDLE next cycle, 2 bytes copied, done stays 0; new start accepted afterwards.
